// File: rtl/lca_seq_ctrl.sv
// Chunk-serial adder: one CHUNK-bit lookahead-carry adder is reused NCHUNK
// times, LSB chunk first, to form a WIDTH-bit sum behind valid/ready handshakes.
module lca_seq_ctrl #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, out_valid_q, out_valid_d;
    logic [CHUNK:0]   add_res_s;

    // Ripple within each 4-bit group; group generate/propagate skip the carry across groups.
    function automatic logic [CHUNK:0] lca_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
        logic [CHUNK-1:0] p, g, s;
        logic c_grp, c_bit, grp_g, grp_p;
        p     = x ^ y;
        g     = x & y;
        s     = '0;
        c_grp = ci;
        for (int gi = 0; gi < CHUNK / 4; gi++) begin
            c_bit = c_grp;
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int k = 0; k < 4; k++) begin
                s[gi*4+k] = p[gi*4+k] ^ c_bit;
                c_bit     = g[gi*4+k] | (p[gi*4+k] & c_bit);
                grp_g     = g[gi*4+k] | (p[gi*4+k] & grp_g);
                grp_p     = grp_p & p[gi*4+k];
            end
            c_grp = grp_g | (grp_p & c_grp);
        end
        return {c_grp, s};
    endfunction

    // Next-state and datapath decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        add_res_s   = lca_add(a_q[int'(idx_q)*CHUNK +: CHUNK],
                              b_q[int'(idx_q)*CHUNK +: CHUNK], carry_q);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[int'(idx_q)*CHUNK +: CHUNK] = add_res_s[CHUNK-1:0];
                carry_d = add_res_s[CHUNK];
                if (idx_q == IDX_LAST) begin
                    cout_d      = add_res_s[CHUNK];
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                idx_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_lca_seq_ctrl.sv
// Bench for lca_seq_ctrl: vector table, directed stall/reset sequences and a
// randomized run, with results checked through an expected-value queue.
module tb_lca_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [63:0] a, b, sum;
    int          n_cmp = 0, n_fail = 0, n_out = 0;
    logic [64:0] sb_q[$];

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        co;
    } vec_t;
    vec_t vecs[8];

    lca_seq_ctrl #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present operands, wait (bounded) for acceptance, record expected result.
    task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic cv,
                        input logic [64:0] exp, output logic ok);
        int guard = 0;
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            @(negedge clk);
            guard++;
        end
        ok = in_ready;
        chk("accept", 65'(in_ready), 65'(1));
        if (ok) begin
            sb_q.push_back(exp);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    // Output-side scoreboard: pop and compare whenever a result handshake is about to occur.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h expected none", {cout, sum});
                end else begin
                    chk("result", {cout, sum}, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int          lat, base;
        logic        ok;
        logic [63:0] hold_sum;
        logic        hold_cout;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
        vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
        vecs[2] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1};
        vecs[5] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[7] = '{64'h7FFF_0000_FFFF_8000, 64'h0001_0000_0000_8000, 1'b0,
                    64'h8000_0001_0000_0000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 64'h0; b = 64'h0; cin = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 65'(in_ready), 65'(1));
        chk("rst_out_valid", 65'(out_valid), 65'(0));
        chk("rst_busy", 65'(busy), 65'(0));
        chk("rst_sum_cout", {cout, sum}, 65'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].co, vecs[i].s}, ok);
            chk($sformatf("vec%0d_busy", i), 65'(busy), 65'(1));
            wait_out(lat);
            chk($sformatf("vec%0d_latency", i), 65'(lat), 65'(4));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_idle", i), 65'({in_ready, out_valid}), 65'(2));
        end

        // Result held back by the consumer while in_valid keeps pulsing.
        out_ready = 1'b0;
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 65'h0_0000_0000_0001_0000, ok);
        wait_out(lat);
        chk("stall_latency", 65'(lat), 65'(4));
        hold_sum  = 64'h0000_0000_0001_0000;
        hold_cout = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = ~in_valid;
            a = {$urandom, $urandom};
            @(negedge clk);
            chk("stall_out_valid", 65'(out_valid), 65'(1));
            chk("stall_result", {cout, sum}, {hold_cout, hold_sum});
            chk("stall_in_ready", 65'(in_ready), 65'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1; in_valid = 1'b1;
        a = 64'h5; b = 64'h6; cin = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_in_ready", 65'(in_ready), 65'(1));
        chk("release_out_valid", 65'(out_valid), 65'(0));
        sb_q.push_back(65'd11);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("release_latency", 65'(lat), 65'(4));
        @(posedge clk); #1;

        // Reset while idx==2 in RUN abandons the operation.
        send(64'h1111_2222_3333_4444, 64'h1, 1'b0, 65'h0_1111_2222_3333_4445, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 65'(out_valid), 65'(0));
        chk("midrst_in_ready", 65'(in_ready), 65'(1));
        chk("midrst_busy", 65'(busy), 65'(0));
        chk("midrst_sum", 65'(sum), 65'(0));
        @(posedge clk); #1;
        send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1,
             65'h0_1234_5678_9ABC_DF01, ok);
        wait_out(lat);
        chk("postrst_latency", 65'(lat), 65'(4));
        @(posedge clk); #1;

        // Random operands with random gaps and consumer back-pressure.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    logic [63:0] ra, rb;
                    logic        rc;
                    int          gap;
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    rc = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) ra = ~rb;
                    send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 65'(rc), ok);
                    if (!ok) break;
                end
            end
            begin
                int cyc = 0;
                while (n_out < base + 2000 && cyc < 60000) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    cyc++;
                end
                out_ready = 1'b1;
            end
        join
        chk("rand_count", 65'(n_out - base), 65'(2000));
        chk("rand_sb_empty", 65'(sb_q.size()), 65'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
